playfield_arb: RTL and testbench
================================

PLAYFIELD_ARB -- requirements
Module: playfield_arb

Interface
REQ-001 Parameter ADDR_W, default 10, playfield RAM address width (1024 tiles).
REQ-002 Parameter DATA_W, default 8, tile code width.
REQ-003 Parameter CLR_VAL, default 8'h00, fill value written by clear engine.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_l  in  1  reset, asynchronous, active-low.
REQ-006 cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-007 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
REQ-008 cpu_addr  in  ADDR_W  CPU address; stable while cpu_req.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_ack  out  1  one-cycle pulse, access complete.
REQ-011 cpu_rdata  out  DATA_W  read data, valid with cpu_ack.
REQ-012 vid_req  in  1  video tile-fetch request, single cycle.
REQ-013 vid_addr  in  ADDR_W  video fetch address.
REQ-014 vid_valid  out  1  pulse, vid_data valid.
REQ-015 vid_data  out  DATA_W  fetched tile code.
REQ-016 clr_start  in  1  pulse, begin full-field clear.
REQ-017 clr_busy  out  1  clear in progress.
REQ-018 clr_done  out  1  one-cycle pulse after final clear write.
REQ-019 ram_addr  out  ADDR_W  RAM address.
REQ-020 ram_we_l  out  1  RAM write enable, active-low.
REQ-021 ram_wdata  out  DATA_W  RAM write data.
REQ-022 ram_rdata  in  DATA_W  RAM read data, combinational from ram_addr.

Function
REQ-023 One RAM access per cycle; fixed priority video > CPU > clear engine.
REQ-024 Grant decided combinationally in cycle N; ram_addr/ram_we_l/ram_wdata driven from the winner in N; ram_we_l = 1 when no write granted.
REQ-025 Video grant: ram_rdata registered at end of N; vid_valid=1, vid_data valid in N+1 (latency 1).
REQ-026 CPU grant: write performed in N; read data registered; cpu_ack=1 and cpu_rdata valid in N+1.
REQ-027 CPU request deasserts cycle after cpu_ack; a cpu_req still high in the cpu_ack cycle is not re-granted until cpu_ack clears (no double access).
REQ-028 CPU starvation permitted while vid_req is asserted every cycle; no timeout.
REQ-029 Clear FSM states IDLE, CLEAR; IDLE->CLEAR on clr_start, counter loads 0.
REQ-030 In CLEAR, each cycle with no video/CPU grant writes CLR_VAL to counter address and increments counter.
REQ-031 CLEAR->IDLE after write to address 2^ADDR_W-1; clr_done pulses the following cycle; counter wraps to 0.
REQ-032 clr_start while CLEAR ignored; clr_busy = (state == CLEAR).
REQ-033 CPU writes during CLEAR allowed; a later clear write may overwrite them (no protection).
REQ-034 vid_valid, cpu_ack, clr_done never high without a corresponding grant/event in previous cycle.

Reset
REQ-035 rst_l low asynchronously forces: state IDLE, counter 0, cpu_ack 0, cpu_rdata 0, vid_valid 0, vid_data 0, clr_busy 0, clr_done 0, ram_we_l 1.
REQ-036 Reset mid-clear abandons clear; no resumption after release.
REQ-037 Pending requests at reset are dropped; requester must re-request.

Structure
REQ-038 Package playfield_pkg holds ADDR_W/DATA_W defaults, CLR_VAL default, and clear-FSM state enum.
REQ-039 Single sub-module pf_clear_seq (FSM + address counter) instantiated inside playfield_arb.

Verification
REQ-040 CPU write addr 10'h123 data 8'hA5, then read 10'h123 -> cpu_ack one cycle after each grant, cpu_rdata=8'hA5.
REQ-041 vid_req and cpu_req same cycle -> video granted first, vid_valid next cycle, CPU ack one cycle later.
REQ-042 clr_start with no traffic -> clr_busy 1024 cycles, clr_done pulse, all RAM reads 8'h00.
REQ-043 clr_start with vid_req every other cycle -> clear completes in 2048 cycles, no video fetch lost.
REQ-044 rst_l low at clear address 10'h200 -> outputs at reset values immediately, clr_busy 0 after release.
REQ-045 cpu_req held for 8 cycles of continuous vid_req -> no cpu_ack until vid_req drops, then exactly one ack.

Source files
------------

// File: rtl/playfield_pkg.sv
// Shared defaults and clear-engine state encoding for the playfield RAM arbiter.
package playfield_pkg;

   localparam int unsigned PF_ADDR_W  = 10;
   localparam int unsigned PF_DATA_W  = 8;
   localparam logic [7:0]  PF_CLR_VAL = 8'h00;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

endpackage

// File: rtl/pf_clear_seq.sv
// Full-field clear sequencer: walks every address once, advancing only on cycles it wins the RAM.
module pf_clear_seq
   import playfield_pkg::*;
#(
   parameter int unsigned ADDR_W = PF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              clr_start,
   input  logic              clr_gnt,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] clr_addr
);

   clr_state_t state;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state    <= IDLE;
         clr_addr <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clr_start) begin
                  state    <= CLEAR;
                  clr_busy <= 1'b1;
                  clr_addr <= '0;
               end
            end
            CLEAR: begin
               if (clr_gnt) begin
                  // counter wraps to zero on the final write
                  clr_addr <= clr_addr + 1'b1;
                  if (&clr_addr) begin
                     state    <= IDLE;
                     clr_busy <= 1'b0;
                     clr_done <= 1'b1;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               clr_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/playfield_arb.sv
// Playfield RAM arbiter: one access per cycle, fixed priority video > CPU > clear engine.
module playfield_arb
   import playfield_pkg::*;
#(
   parameter int unsigned       ADDR_W  = PF_ADDR_W,
   parameter int unsigned       DATA_W  = PF_DATA_W,
   parameter logic [DATA_W-1:0] CLR_VAL = PF_CLR_VAL
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_valid,
   output logic [DATA_W-1:0] vid_data,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we_l,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic              vid_gnt;
   logic              cpu_gnt;
   logic              clr_gnt;
   logic [ADDR_W-1:0] clr_addr;

   // Grants are held off during reset so no write strobe escapes while rst_l is low;
   // a CPU request is not re-granted in its own ack cycle.
   assign vid_gnt = rst_l & vid_req;
   assign cpu_gnt = rst_l & cpu_req & ~vid_req & ~cpu_ack;
   assign clr_gnt = clr_busy & ~vid_req & ~cpu_gnt;

   always_comb begin
      ram_addr  = clr_addr;
      ram_wdata = CLR_VAL;
      ram_we_l  = 1'b1;
      if (vid_gnt) begin
         ram_addr = vid_addr;
      end else if (cpu_gnt) begin
         ram_addr  = cpu_addr;
         ram_wdata = cpu_wdata;
         ram_we_l  = ~cpu_we;
      end else if (clr_gnt) begin
         ram_we_l = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         vid_valid <= 1'b0;
         vid_data  <= '0;
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         vid_valid <= vid_gnt;
         cpu_ack   <= cpu_gnt;
         if (vid_gnt) vid_data <= ram_rdata;
         if (cpu_gnt && !cpu_we) cpu_rdata <= ram_rdata;
      end
   end

   pf_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk       (clk),
      .rst_l     (rst_l),
      .clr_start (clr_start),
      .clr_gnt   (clr_gnt),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .clr_addr  (clr_addr)
   );

endmodule

// File: tb/tb_playfield_arb.sv
// Scoreboard bench for playfield_arb with a behavioural RAM and an independent shadow of intended contents.
module tb_playfield_arb;

   logic       clk = 1'b0;
   logic       rst_l;
   logic       cpu_req, cpu_we;
   logic [9:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_ack;
   logic [7:0] cpu_rdata;
   logic       vid_req;
   logic [9:0] vid_addr;
   logic       vid_valid;
   logic [7:0] vid_data;
   logic       clr_start, clr_busy, clr_done;
   logic [9:0] ram_addr;
   logic       ram_we_l;
   logic [7:0] ram_wdata, ram_rdata;

   logic [7:0] mem    [1024];
   logic [7:0] shadow [1024];

   typedef struct {
      logic       chk;
      logic [7:0] data;
   } exp_t;

   exp_t vid_q[$];
   exp_t cpu_q[$];

   int unsigned nvec = 0;
   int unsigned nerr = 0;
   int unsigned nvid_req = 0;
   int unsigned nvid_valid = 0;

   playfield_arb #(
      .ADDR_W  (10),
      .DATA_W  (8),
      .CLR_VAL (8'h00)
   ) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_valid (vid_valid),
      .vid_data  (vid_data),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .ram_addr  (ram_addr),
      .ram_we_l  (ram_we_l),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   initial forever #5 clk = ~clk;

   assign ram_rdata = mem[ram_addr];

   always @(posedge clk) begin
      if (!ram_we_l) mem[ram_addr] <= ram_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output-side monitor: every valid/ack pops the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (vid_valid) begin
         nvid_valid++;
         if (vid_q.size() == 0) chk("vid_spurious", 1, 0);
         else begin
            e = vid_q.pop_front();
            if (e.chk) chk("vid_data", {24'h0, vid_data}, {24'h0, e.data});
         end
      end
      if (cpu_ack) begin
         if (cpu_q.size() == 0) chk("cpu_spurious", 1, 0);
         else begin
            e = cpu_q.pop_front();
            if (e.chk) chk("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, e.data});
         end
      end
   end

   task automatic push_vid(input logic [9:0] a, input logic c);
      exp_t e;
      e.chk  = c;
      e.data = shadow[a];
      vid_q.push_back(e);
      nvid_req++;
   endtask

   task automatic vid_fetch(input logic [9:0] a);
      vid_req  = 1'b1;
      vid_addr = a;
      push_vid(a, 1'b1);
      tick();
      vid_req = 1'b0;
      tick();
   endtask

   // Uncontended CPU access; request is held through the ack cycle to probe for a double grant.
   task automatic cpu_access(input logic we, input logic [9:0] a, input logic [7:0] wd);
      exp_t e;
      int unsigned n;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      e.chk  = !we;
      e.data = shadow[a];
      cpu_q.push_back(e);
      if (we) shadow[a] = wd;
      n = 0;
      do begin
         tick();
         n++;
      end while (!cpu_ack && n < 50);
      chk("cpu_ack_seen", cpu_ack, 1);
      chk("cpu_latency", n, 1);
      tick();
      chk("cpu_no_double", cpu_ack, 0);
      cpu_req = 1'b0;
   endtask

   task automatic run_clear(input logic alt_vid, output int unsigned cyc);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      chk("clr_busy_start", clr_busy, 1);
      cyc = 0;
      while (clr_busy && cyc < 5000) begin
         vid_req = alt_vid && (cyc % 2 == 0);
         if (vid_req) begin
            vid_addr = 10'($urandom_range(0, 1023));
            push_vid(vid_addr, 1'b0);
         end
         tick();
         cyc++;
      end
      vid_req = 1'b0;
      chk("clr_done_pulse", clr_done, 1);
      for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;
      tick();
      chk("clr_done_once", clr_done, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cpu_ack"}, cpu_ack, 0);
      chk({tag, "_cpu_rdata"}, {24'h0, cpu_rdata}, 0);
      chk({tag, "_vid_valid"}, vid_valid, 0);
      chk({tag, "_vid_data"}, {24'h0, vid_data}, 0);
      chk({tag, "_clr_busy"}, clr_busy, 0);
      chk({tag, "_clr_done"}, clr_done, 0);
      chk({tag, "_ram_we_l"}, ram_we_l, 1);
   endtask

   initial begin
      int unsigned cyc;
      int unsigned nz;
      int unsigned acks;
      for (int i = 0; i < 1024; i++) begin
         mem[i]    = 8'($urandom_range(1, 255));
         shadow[i] = mem[i];
      end
      rst_l = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      vid_req = 1'b0; vid_addr = '0; clr_start = 1'b0;
      #1;
      check_reset_outputs("rst0");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_l = 1'b1;
      tick();
      check_reset_outputs("post_rst");

      // Video read of untouched random contents
      vid_fetch(10'h2a7);

      // Full clear with no traffic
      run_clear(1'b0, cyc);
      chk("clr_cycles_idle", cyc, 1024);
      nz = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== 8'h00) nz++;
      chk("clr_nonzero_cells", nz, 0);
      vid_fetch(10'h000);
      vid_fetch(10'h3ff);

      // CPU write then read back
      cpu_access(1'b1, 10'h123, 8'ha5);
      cpu_access(1'b0, 10'h123, 8'h00);
      cpu_access(1'b1, 10'h050, 8'h3c);

      // Simultaneous video and CPU requests: video first
      vid_req = 1'b1; vid_addr = 10'h123; push_vid(10'h123, 1'b1);
      begin
         exp_t e;
         e.chk = 1'b1; e.data = shadow[10'h050];
         cpu_q.push_back(e);
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h050;
      tick();
      chk("race_vid_first", vid_valid, 1);
      chk("race_cpu_wait", cpu_ack, 0);
      vid_req = 1'b0;
      tick();
      chk("race_cpu_ack", cpu_ack, 1);
      chk("race_vid_off", vid_valid, 0);
      tick();
      chk("race_cpu_no_double", cpu_ack, 0);
      cpu_req = 1'b0;
      tick();

      // CPU starved by 8 cycles of continuous video
      acks = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h123;
      begin
         exp_t e;
         e.chk = 1'b1; e.data = shadow[10'h123];
         cpu_q.push_back(e);
      end
      for (int i = 0; i < 8; i++) begin
         vid_req  = 1'b1;
         vid_addr = (i % 2 == 0) ? 10'h050 : 10'h123;
         push_vid(vid_addr, 1'b1);
         tick();
         if (cpu_ack) acks++;
      end
      vid_req = 1'b0;
      chk("starve_no_ack", acks, 0);
      tick();
      chk("starve_ack", cpu_ack, 1);
      tick();
      chk("starve_single_ack", cpu_ack, 0);
      cpu_req = 1'b0;
      tick();

      // Clear interleaved with video every other cycle
      run_clear(1'b1, cyc);
      chk("clr_cycles_alt", cyc, 2048);
      vid_fetch(10'h123);

      // Reset in the middle of a clear
      cpu_access(1'b1, 10'h300, 8'h77);
      cpu_access(1'b0, 10'h300, 8'h00);
      vid_fetch(10'h300);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      repeat (10'h200) tick();
      chk("mid_clr_addr", {22'h0, ram_addr}, 32'h200);
      chk("mid_clr_we", ram_we_l, 0);
      rst_l = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      rst_l = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("no_resume_busy", clr_busy, 0);
      chk("no_resume_we", ram_we_l, 1);
      cpu_access(1'b0, 10'h300, 8'h00);
      cpu_access(1'b0, 10'h123, 8'h00);

      repeat (3) tick();
      chk("vid_count", nvid_valid, nvid_req);
      chk("vid_q_empty", vid_q.size(), 0);
      chk("cpu_q_empty", cpu_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
